// File: rtl/mem_bus_arbiter_pkg.sv
// Shared definitions for the two-master memory bus arbiter: master IDs,
// arbiter state encoding and bus field widths.
package mem_bus_arbiter_pkg;

    localparam logic MASTER_CPU = 1'b0;
    localparam logic MASTER_AUX = 1'b1;

    localparam int ADDR_W = 32;
    localparam int DATA_W = 32;
    localparam int BE_W   = 4;

    typedef enum logic {
        ARB_IDLE = 1'b0,
        ARB_HOLD = 1'b1
    } arb_state_e;

endpackage

// File: rtl/mem_arb_id_fifo.sv
// In-order ID FIFO: one bit per outstanding read, recording which master
// issued it so the response can be steered back. Push/pop in the same
// cycle keep the count unchanged; a push while full or a pop while empty
// is ignored.
module mem_arb_id_fifo #(
    parameter int DEPTH = 4
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     push,
    input  logic                     push_id,
    input  logic                     pop,
    output logic                     head,
    output logic [$clog2(DEPTH):0]   count,
    output logic                     full,
    output logic                     empty
);

    localparam int PW = $clog2(DEPTH);

    logic [DEPTH-1:0] mem;
    logic [PW-1:0]    wr_ptr;
    logic [PW-1:0]    rd_ptr;
    logic             do_push;
    logic             do_pop;

    assign full    = (count == (PW + 1)'(DEPTH));
    assign empty   = (count == '0);
    assign do_push = push && !full;
    assign do_pop  = pop && !empty;
    assign head    = mem[rd_ptr];

    // Storage, pointers and occupancy; reset discards all contents.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mem    <= '0;
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) begin
                mem[wr_ptr] <= push_id;
                wr_ptr      <= wr_ptr + PW'(1);
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + PW'(1);
            end
            if (do_push && !do_pop) begin
                count <= count + (PW + 1)'(1);
            end else if (do_pop && !do_push) begin
                count <= count - (PW + 1)'(1);
            end
        end
    end

endmodule

// File: rtl/mem_bus_arbiter.sv
// Two-master arbiter for the shared mem_cmd/mem_rsp slave bus.
// Master 0 is the CPU, master 1 the auxiliary master. Commands pass through
// combinationally; a command stalled by the slave freezes the grant until it
// is accepted. Read responses come back in issue order and are steered via
// an in-order ID FIFO.
// Build option: MEM_BUS_ARBITER_RR_EN selects round-robin arbitration;
// otherwise master 0 has fixed priority.
// Handshake: a command transfers on a cycle where s_cmd_valid && s_cmd_ready;
// s_cmd_valid never depends on s_cmd_ready, and mN_cmd_ready is asserted only
// in the cycle the granted master's command transfers.
module mem_bus_arbiter
    import mem_bus_arbiter_pkg::*;
#(
    parameter int OUTSTANDING_DEPTH = 4
) (
    input  logic                                clk,
    input  logic                                reset_,
    input  logic                                m0_cmd_valid,
    output logic                                m0_cmd_ready,
    input  logic                                m0_cmd_wr,
    input  logic                                m0_cmd_instr,
    input  logic [ADDR_W-1:0]                   m0_cmd_addr,
    input  logic [DATA_W-1:0]                   m0_cmd_wdata,
    input  logic [BE_W-1:0]                     m0_cmd_be,
    output logic                                m0_rsp_ready,
    output logic [DATA_W-1:0]                   m0_rsp_rdata,
    input  logic                                m1_cmd_valid,
    output logic                                m1_cmd_ready,
    input  logic                                m1_cmd_wr,
    input  logic                                m1_cmd_instr,
    input  logic [ADDR_W-1:0]                   m1_cmd_addr,
    input  logic [DATA_W-1:0]                   m1_cmd_wdata,
    input  logic [BE_W-1:0]                     m1_cmd_be,
    output logic                                m1_rsp_ready,
    output logic [DATA_W-1:0]                   m1_rsp_rdata,
    output logic                                s_cmd_valid,
    input  logic                                s_cmd_ready,
    output logic                                s_cmd_wr,
    output logic                                s_cmd_instr,
    output logic [ADDR_W-1:0]                   s_cmd_addr,
    output logic [DATA_W-1:0]                   s_cmd_wdata,
    output logic [BE_W-1:0]                     s_cmd_be,
    input  logic                                s_rsp_ready,
    input  logic [DATA_W-1:0]                   s_rsp_rdata,
    output logic                                arb_err,
    output arb_state_e                          state,
    output logic [$clog2(OUTSTANDING_DEPTH):0]  outstanding
);

    arb_state_e state_q;
    arb_state_e state_d;
    logic       grant_q;
    logic       grant;
    logic       winner;
    logic       elig0;
    logic       elig1;
    logic       cmd_valid;
    logic       accept;
    logic       sel_wr;
    logic       fifo_push;
    logic       fifo_pop;
    logic       fifo_head;
    logic       fifo_full;
    logic       fifo_empty;
    logic [$clog2(OUTSTANDING_DEPTH):0] fifo_count;

    // A read is only eligible when a FIFO slot is free now; a same-cycle pop
    // does not make room.
    assign elig0 = m0_cmd_valid && (m0_cmd_wr || !fifo_full);
    assign elig1 = m1_cmd_valid && (m1_cmd_wr || !fifo_full);

`ifdef MEM_BUS_ARBITER_RR_EN
    logic rr_ptr;

    // Round-robin pick: rr_ptr names the preferred master on a tie.
    always_comb begin
        winner = MASTER_CPU;
        if (elig0 && elig1) begin
            winner = rr_ptr;
        end else if (elig1) begin
            winner = MASTER_AUX;
        end
    end

    // Preference flips after every accepted command.
    always_ff @(posedge clk or negedge reset_) begin
        if (!reset_) begin
            rr_ptr <= MASTER_CPU;
        end else if (accept) begin
            rr_ptr <= ~rr_ptr;
        end
    end
`else
    // Fixed-priority pick: the CPU wins whenever it is eligible.
    always_comb begin
        winner = MASTER_CPU;
        if (!elig0 && elig1) begin
            winner = MASTER_AUX;
        end
    end
`endif

    // Grant selection and next state: a stalled command freezes the grant.
    always_comb begin
        state_d   = state_q;
        grant     = winner;
        if (state_q == ARB_HOLD) begin
            grant = grant_q;
        end
        cmd_valid = grant ? elig1 : elig0;
        case (state_q)
            ARB_IDLE: if (cmd_valid && !s_cmd_ready) state_d = ARB_HOLD;
            ARB_HOLD: if (!cmd_valid || s_cmd_ready) state_d = ARB_IDLE;
            default:  state_d = ARB_IDLE;
        endcase
    end

    // State register and frozen grant (captured while deciding in IDLE).
    always_ff @(posedge clk or negedge reset_) begin
        if (!reset_) begin
            state_q <= ARB_IDLE;
            grant_q <= MASTER_CPU;
        end else begin
            state_q <= state_d;
            if (state_q == ARB_IDLE) begin
                grant_q <= grant;
            end
        end
    end

    assign accept    = cmd_valid && s_cmd_ready;
    assign sel_wr    = grant ? m1_cmd_wr : m0_cmd_wr;
    assign fifo_push = accept && !sel_wr;
    assign fifo_pop  = s_rsp_ready && !fifo_empty;

    mem_arb_id_fifo #(
        .DEPTH (OUTSTANDING_DEPTH)
    ) u_id_fifo (
        .clk     (clk),
        .rst_n   (reset_),
        .push    (fifo_push),
        .push_id (grant),
        .pop     (fifo_pop),
        .head    (fifo_head),
        .count   (fifo_count),
        .full    (fifo_full),
        .empty   (fifo_empty)
    );

    // Sticky error for a response arriving with nothing outstanding.
    always_ff @(posedge clk or negedge reset_) begin
        if (!reset_) begin
            arb_err <= 1'b0;
        end else if (s_rsp_ready && fifo_empty) begin
            arb_err <= 1'b1;
        end
    end

    // Outputs are forced low while reset is asserted.
    assign s_cmd_valid  = reset_ && cmd_valid;
    assign s_cmd_wr     = reset_ && sel_wr;
    assign s_cmd_instr  = reset_ && (grant ? m1_cmd_instr : m0_cmd_instr);
    assign s_cmd_addr   = {ADDR_W{reset_}} & (grant ? m1_cmd_addr  : m0_cmd_addr);
    assign s_cmd_wdata  = {DATA_W{reset_}} & (grant ? m1_cmd_wdata : m0_cmd_wdata);
    assign s_cmd_be     = {BE_W{reset_}}   & (grant ? m1_cmd_be    : m0_cmd_be);
    assign m0_cmd_ready = reset_ && accept && (grant == MASTER_CPU);
    assign m1_cmd_ready = reset_ && accept && (grant == MASTER_AUX);
    assign m0_rsp_ready = reset_ && fifo_pop && (fifo_head == MASTER_CPU);
    assign m1_rsp_ready = reset_ && fifo_pop && (fifo_head == MASTER_AUX);
    assign m0_rsp_rdata = {DATA_W{reset_}} & s_rsp_rdata;
    assign m1_rsp_rdata = {DATA_W{reset_}} & s_rsp_rdata;
    assign state        = state_q;
    assign outstanding  = fifo_count;

endmodule

// File: tb/tb_mem_bus_arbiter.sv
// Bench for mem_bus_arbiter: directed scenarios followed by random traffic,
// checked cycle by cycle against a transaction-level reference model.
module tb_mem_bus_arbiter;
    import mem_bus_arbiter_pkg::*;

    localparam int DEPTH = 4;

    // ---------------- clock / reset ----------------
    logic clk = 1'b0;
    logic reset_;
    always #5 clk = ~clk;

    logic        m0_cmd_valid, m0_cmd_ready, m0_cmd_wr, m0_cmd_instr;
    logic [31:0] m0_cmd_addr, m0_cmd_wdata;
    logic [3:0]  m0_cmd_be;
    logic        m0_rsp_ready;
    logic [31:0] m0_rsp_rdata;
    logic        m1_cmd_valid, m1_cmd_ready, m1_cmd_wr, m1_cmd_instr;
    logic [31:0] m1_cmd_addr, m1_cmd_wdata;
    logic [3:0]  m1_cmd_be;
    logic        m1_rsp_ready;
    logic [31:0] m1_rsp_rdata;
    logic        s_cmd_valid, s_cmd_ready, s_cmd_wr, s_cmd_instr;
    logic [31:0] s_cmd_addr, s_cmd_wdata;
    logic [3:0]  s_cmd_be;
    logic        s_rsp_ready;
    logic [31:0] s_rsp_rdata;
    logic        arb_err;
    arb_state_e  state;
    logic [2:0]  outstanding;

    mem_bus_arbiter #(.OUTSTANDING_DEPTH(DEPTH)) dut (
        .clk(clk), .reset_(reset_),
        .m0_cmd_valid(m0_cmd_valid), .m0_cmd_ready(m0_cmd_ready), .m0_cmd_wr(m0_cmd_wr),
        .m0_cmd_instr(m0_cmd_instr), .m0_cmd_addr(m0_cmd_addr), .m0_cmd_wdata(m0_cmd_wdata),
        .m0_cmd_be(m0_cmd_be), .m0_rsp_ready(m0_rsp_ready), .m0_rsp_rdata(m0_rsp_rdata),
        .m1_cmd_valid(m1_cmd_valid), .m1_cmd_ready(m1_cmd_ready), .m1_cmd_wr(m1_cmd_wr),
        .m1_cmd_instr(m1_cmd_instr), .m1_cmd_addr(m1_cmd_addr), .m1_cmd_wdata(m1_cmd_wdata),
        .m1_cmd_be(m1_cmd_be), .m1_rsp_ready(m1_rsp_ready), .m1_rsp_rdata(m1_rsp_rdata),
        .s_cmd_valid(s_cmd_valid), .s_cmd_ready(s_cmd_ready), .s_cmd_wr(s_cmd_wr),
        .s_cmd_instr(s_cmd_instr), .s_cmd_addr(s_cmd_addr), .s_cmd_wdata(s_cmd_wdata),
        .s_cmd_be(s_cmd_be), .s_rsp_ready(s_rsp_ready), .s_rsp_rdata(s_rsp_rdata),
        .arb_err(arb_err), .state(state), .outstanding(outstanding)
    );

    // ---------------- scoreboard / reference model ----------------
    logic [0:0] exp_q[$];   // master IDs of reads in flight, oldest first
    int         held_m;     // master whose stalled command is frozen, -1 if none
    int         pref;       // preferred master on a tie (round-robin build)
    logic       exp_err;
    int         n_vec  = 0;
    int         n_miss = 0;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_miss++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic void model_reset();
        exp_q.delete();
        held_m  = -1;
        pref    = 0;
        exp_err = 1'b0;
    endfunction

    // Check this cycle's outputs against the model, then advance the model
    // by one clock and move to the next falling edge.
    task automatic tick();
        logic el0, el1, ev, wr_g, rsp_hit;
        int   g;
        #1;
        el0 = m0_cmd_valid && (m0_cmd_wr || exp_q.size() < DEPTH);
        el1 = m1_cmd_valid && (m1_cmd_wr || exp_q.size() < DEPTH);
        if (held_m >= 0)        g = held_m;
`ifdef MEM_BUS_ARBITER_RR_EN
        else if (el0 && el1)    g = pref;
`else
        else if (el0 && el1)    g = 0;
`endif
        else if (el1)           g = 1;
        else                    g = 0;
        ev   = (g == 1) ? el1 : el0;
        wr_g = (g == 1) ? m1_cmd_wr : m0_cmd_wr;
        check("s_cmd_valid", s_cmd_valid, ev);
        check("m0_cmd_ready", m0_cmd_ready, ev && s_cmd_ready && g == 0);
        check("m1_cmd_ready", m1_cmd_ready, ev && s_cmd_ready && g == 1);
        check("s_cmd_addr", s_cmd_addr, (g == 1) ? m1_cmd_addr : m0_cmd_addr);
        check("s_cmd_wdata", s_cmd_wdata, (g == 1) ? m1_cmd_wdata : m0_cmd_wdata);
        check("s_cmd_ctl", {s_cmd_wr, s_cmd_instr, s_cmd_be},
              (g == 1) ? {m1_cmd_wr, m1_cmd_instr, m1_cmd_be} : {m0_cmd_wr, m0_cmd_instr, m0_cmd_be});
        rsp_hit = s_rsp_ready && (exp_q.size() > 0);
        if (rsp_hit) begin
            check("m0_rsp_ready", m0_rsp_ready, exp_q[0] == 1'b0);
            check("m1_rsp_ready", m1_rsp_ready, exp_q[0] == 1'b1);
            check("rsp_rdata", {m0_rsp_rdata, m1_rsp_rdata}, {s_rsp_rdata, s_rsp_rdata});
        end else begin
            check("rsp_ready_idle", {m0_rsp_ready, m1_rsp_ready}, 2'b00);
        end
        check("arb_err", arb_err, exp_err);
        check("outstanding", outstanding, exp_q.size());
        check("state_hold", state, held_m >= 0);
        if (s_rsp_ready) begin
            if (exp_q.size() > 0) void'(exp_q.pop_front());
            else                  exp_err = 1'b1;
        end
        if (ev && s_cmd_ready) begin
            if (!wr_g) exp_q.push_back(g[0]);
            pref   = 1 - pref;
            held_m = -1;
        end else if (ev) begin
            held_m = g;
        end else begin
            held_m = -1;
        end
        @(negedge clk);
    endtask

    // ---------------- driver tasks ----------------
    task automatic drive(input int n, input logic v, input logic wr, input logic [31:0] addr);
        if (n == 0) begin
            m0_cmd_valid = v; m0_cmd_wr = wr; m0_cmd_addr = addr;
            m0_cmd_wdata = $urandom; m0_cmd_be = 4'($urandom); m0_cmd_instr = 1'($urandom);
        end else begin
            m1_cmd_valid = v; m1_cmd_wr = wr; m1_cmd_addr = addr;
            m1_cmd_wdata = $urandom; m1_cmd_be = 4'($urandom); m1_cmd_instr = 1'($urandom);
        end
    endtask

    task automatic idle_all();
        drive(0, 1'b0, 1'b0, 32'h0);
        drive(1, 1'b0, 1'b0, 32'h0);
        s_cmd_ready = 1'b0;
        s_rsp_ready = 1'b0;
    endtask

    task automatic rsp(input logic v, input logic [31:0] d);
        s_rsp_ready = v;
        s_rsp_rdata = d;
    endtask

    // Async reset with live inputs: every output must read zero.
    task automatic reset_pulse();
        drive(0, 1'b1, 1'b0, 32'hFFFF_FFFF);
        drive(1, 1'b1, 1'b1, 32'hFFFF_FFFF);
        s_cmd_ready = 1'b1;
        rsp(1'b1, 32'hA5A5_A5A5);
        reset_ = 1'b0;
        #1;
        check("rst_s_cmd", {s_cmd_valid, s_cmd_wr, s_cmd_instr, s_cmd_be}, 0);
        check("rst_s_addr_wdata", {s_cmd_addr, s_cmd_wdata}, 0);
        check("rst_cmd_ready", {m0_cmd_ready, m1_cmd_ready, m0_rsp_ready, m1_rsp_ready}, 0);
        check("rst_rdata", {m0_rsp_rdata, m1_rsp_rdata}, 0);
        check("rst_err_cnt", {arb_err, state, outstanding}, 0);
        model_reset();
        idle_all();
        @(negedge clk);
        reset_ = 1'b1;
    endtask

    // ---------------- stimulus ----------------
    initial begin
        reset_      = 1'b0;
        s_rsp_rdata = 32'h0;
        idle_all();
        model_reset();
        @(negedge clk);
        reset_pulse();

        // Lone CPU read, response two cycles later.
        drive(0, 1'b1, 1'b0, 32'h100); s_cmd_ready = 1'b1;
        tick();
        drive(0, 1'b0, 1'b0, 32'h0);
        tick();
        tick();
        rsp(1'b1, 32'hDEAD_BEEF);
        tick();
        rsp(1'b0, 32'h0);
        tick();

        // Both masters issuing writes every cycle.
        for (int i = 0; i < 4; i++) begin
            drive(0, 1'b1, 1'b1, 32'h200 + 32'(i));
            drive(1, 1'b1, 1'b1, 32'h300 + 32'(i));
            s_cmd_ready = 1'b1;
            tick();
        end
        idle_all();
        tick();

        // Stalled CPU write; AUX arrives mid-stall and must wait.
        drive(0, 1'b1, 1'b1, 32'h400); s_cmd_ready = 1'b0;
        tick();
        drive(1, 1'b1, 1'b1, 32'h500);
        tick();
        tick();
        s_cmd_ready = 1'b1;
        tick();
        drive(0, 1'b0, 1'b0, 32'h0);
        tick();
        idle_all();
        tick();

        // AUX fills the ID FIFO; fifth read stalls while a CPU write passes.
        s_cmd_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            drive(1, 1'b1, 1'b0, 32'h600 + 32'(4 * i));
            tick();
        end
        drive(1, 1'b1, 1'b0, 32'h610);
        drive(0, 1'b1, 1'b1, 32'h700);
        tick();
        drive(0, 1'b0, 1'b0, 32'h0);
        rsp(1'b1, 32'h1111_0000);
        tick();
        rsp(1'b0, 32'h0);
        tick();
        drive(1, 1'b0, 1'b0, 32'h0);
        for (int i = 0; i < 4; i++) begin
            rsp(1'b1, 32'h2222_0000 + 32'(i));
            tick();
        end
        idle_all();
        tick();

        // Interleaved reads; responses must be steered in issue order.
        s_cmd_ready = 1'b1;
        drive(0, 1'b1, 1'b0, 32'h800); tick();
        drive(0, 1'b0, 1'b0, 32'h0);
        drive(1, 1'b1, 1'b0, 32'h900); tick();
        drive(1, 1'b0, 1'b0, 32'h0);
        drive(0, 1'b1, 1'b0, 32'h804); tick();
        drive(0, 1'b0, 1'b0, 32'h0);
        rsp(1'b1, 32'h1); tick();
        rsp(1'b1, 32'h2); tick();
        rsp(1'b1, 32'h3); tick();
        idle_all();
        tick();

        // Orphan response sets the sticky error; reset clears it and the FIFO.
        rsp(1'b1, 32'hBAD0_0001); tick();
        rsp(1'b0, 32'h0); tick();
        tick();
        s_cmd_ready = 1'b1;
        drive(0, 1'b1, 1'b0, 32'hA00); tick();
        drive(0, 1'b0, 1'b0, 32'h0);
        drive(1, 1'b1, 1'b0, 32'hB00); tick();
        idle_all();
        tick();
        reset_pulse();
        tick();
        rsp(1'b1, 32'hBAD0_0002); tick();
        rsp(1'b0, 32'h0); tick();

        // Random traffic, including stalls and dropped valids.
        for (int c = 0; c < 800; c++) begin
            drive(0, $urandom_range(0, 9) < 6, 1'($urandom), $urandom);
            drive(1, $urandom_range(0, 9) < 6, 1'($urandom), $urandom);
            s_cmd_ready = $urandom_range(0, 9) < 7;
            if (exp_q.size() > 0) rsp($urandom_range(0, 2) == 0, $urandom);
            else                  rsp($urandom_range(0, 99) == 0, $urandom);
            tick();
            if (c == 400) reset_pulse();
        end
        idle_all();
        tick();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule
